int_div_iter: RTL

Iterative 32-bit integer divider with val/rdy request and response interfaces. It is the inverse-operation counterpart of the iterative multiplier in the lab1 arithmetic units. It accepts a {dividend, divisor} operand pair and returns {remainder, quotient} after a fixed number of restoring shift-subtract iterations. It sits behind the same val/rdy message conventions so test sources/sinks and the processor's M-extension path can use it unchanged.

---
 rtl/int_div_pkg.sv | 23 ++
 rtl/int_div_iter_dpath.sv | 91 +++++++++
 rtl/int_div_iter.sv | 83 ++++++++
 3 files changed

// File: rtl/int_div_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// int_div_pkg -- shared types and constants for the iterative divider
// Rev 1.0
// ----------------------------------------------------------------------
package int_div_pkg;

  localparam int NBITS = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [NBITS-1:0] abs_val(input logic [NBITS-1:0] x);
    return x[NBITS-1] ? ((~x) + NBITS'(1)) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_div_iter_dpath.sv
`default_nettype none
// ----------------------------------------------------------------------
// int_div_iter_dpath -- R/Q/D registers, restoring subtractor, counter and
// output sign fix (signed operands when INT_DIV_SIGNED_EN is defined)
// Rev 1.0
// ----------------------------------------------------------------------
module int_div_iter_dpath
  import int_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 sub_sel,
  input  logic [2*NBITS-1:0]   req_msg,
  output logic                 diff_msb,
  output logic                 cnt_last,
  output logic [2*NBITS-1:0]   resp_msg
);

  logic [NBITS:0]     r_rem;
  logic [NBITS-1:0]   r_quo;
  logic [NBITS-1:0]   r_div;
  logic [CNT_W-1:0]   r_cnt;

  logic [2*NBITS:0]   w_rq_sh;
  logic [NBITS:0]     w_rem_sh;
  logic [NBITS:0]     w_diff;
  logic [NBITS-1:0]   w_quo_nx;
  logic [NBITS-1:0]   w_dvd_in;
  logic [NBITS-1:0]   w_dvs_in;
  logic [NBITS-1:0]   w_quo_out;
  logic [NBITS-1:0]   w_rem_out;

  assign w_rq_sh  = {r_rem, r_quo} << 1;
  assign w_rem_sh = w_rq_sh[2*NBITS:NBITS];
  assign w_diff   = w_rem_sh - {1'b0, r_div};
  assign w_quo_nx = w_rq_sh[NBITS-1:0] | {{(NBITS-1){1'b0}}, sub_sel};

  assign diff_msb = w_diff[NBITS];
  assign cnt_last = (r_cnt == CNT_W'(ITERS-1));

`ifdef INT_DIV_SIGNED_EN
  logic r_neg_dvd;
  logic r_neg_dvs;

  assign w_dvd_in = abs_val(req_msg[2*NBITS-1:NBITS]);
  assign w_dvs_in = abs_val(req_msg[NBITS-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_neg_dvd <= 1'b0;
      r_neg_dvs <= 1'b0;
    end else if (load) begin
      r_neg_dvd <= req_msg[2*NBITS-1];
      r_neg_dvs <= req_msg[NBITS-1];
    end
  end

  // A zero divisor keeps the all-ones quotient regardless of operand signs
  assign w_quo_out = ((r_neg_dvd ^ r_neg_dvs) && (r_div != '0)) ? -r_quo : r_quo;
  assign w_rem_out = r_neg_dvd ? -r_rem[NBITS-1:0] : r_rem[NBITS-1:0];
`else
  assign w_dvd_in  = req_msg[2*NBITS-1:NBITS];
  assign w_dvs_in  = req_msg[NBITS-1:0];
  assign w_quo_out = r_quo;
  assign w_rem_out = r_rem[NBITS-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_rem <= '0;
      r_quo <= w_dvd_in;
      r_div <= w_dvs_in;
      r_cnt <= '0;
    end else if (step) begin
      r_rem <= sub_sel ? w_diff : w_rem_sh;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign resp_msg = {w_rem_out, w_quo_out};

endmodule
`default_nettype wire

// File: rtl/int_div_iter.sv
`default_nettype none
// ----------------------------------------------------------------------
// int_div_iter -- iterative restoring 32-bit divider, val/rdy in and out;
// INT_DIV_SIGNED_EN selects signed DIV/REM instead of DIVU/REMU
// Rev 1.0
// ----------------------------------------------------------------------
module int_div_iter
  import int_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [2*NBITS-1:0]   req_msg,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [2*NBITS-1:0]   resp_msg
);

  state_e r_state;
  state_e w_state_nx;

  logic w_load;
  logic w_step;
  logic w_sub_sel;
  logic w_diff_msb;
  logic w_cnt_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    req_rdy    = 1'b0;
    resp_val   = 1'b0;
    w_load     = 1'b0;
    w_step     = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          w_load     = 1'b1;
          w_state_nx = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (w_cnt_last) begin
          w_state_nx = DONE;
        end
      end
      DONE: begin
        resp_val = 1'b1;
        if (resp_rdy) begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Restore (keep shifted R) whenever the trial subtraction went negative
  assign w_sub_sel = w_step & ~w_diff_msb;

  int_div_iter_dpath u_dpath (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .step     (w_step),
    .sub_sel  (w_sub_sel),
    .req_msg  (req_msg),
    .diff_msb (w_diff_msb),
    .cnt_last (w_cnt_last),
    .resp_msg (resp_msg)
  );

endmodule
`default_nettype wire
